// File: rtl/intersection_pkg.sv
// Shared phase encodings, timing defaults and green-duration clamp limits
// for the two-road intersection sequencer.
package intersection_pkg;

  typedef enum logic [2:0] {
    PH_GREEN_A   = 3'd0,
    PH_YELLOW_A  = 3'd1,
    PH_ALLRED_AB = 3'd2,
    PH_GREEN_B   = 3'd3,
    PH_YELLOW_B  = 3'd4,
    PH_ALLRED_BA = 3'd5,
    PH_HOLD      = 3'd6
  } phase_e;

  localparam int YELLOW_T_DEF = 3;
  localparam int ALLRED_T_DEF = 2;
  localparam int STEP_DEF     = 5;

  localparam logic [6:0] DUR_A_RST = 7'd40;
  localparam logic [6:0] DUR_B_RST = 7'd50;

  localparam logic [6:0] A_MIN_NORM = 7'd40;
  localparam logic [6:0] A_MAX_NORM = 7'd70;
  localparam logic [6:0] B_MIN_NORM = 7'd50;
  localparam logic [6:0] B_MAX_NORM = 7'd80;
  localparam logic [6:0] A_MIN_RUSH = 7'd30;
  localparam logic [6:0] A_MAX_RUSH = 7'd60;
  localparam logic [6:0] B_MIN_RUSH = 7'd40;
  localparam logic [6:0] B_MAX_RUSH = 7'd70;

  function automatic logic [6:0] clamp_dur(input logic [7:0] v,
                                           input logic [6:0] lo,
                                           input logic [6:0] hi);
    if (v < {1'b0, lo})      return lo;
    else if (v > {1'b0, hi}) return hi;
    else                     return v[6:0];
  endfunction

endpackage

// File: rtl/intersection_phase_sequencer_green_duration_calc.sv
// Combinational green-duration adaptation: step the duration by queue length,
// then clamp to the road's window (normal or rush-hour).
module green_duration_calc
  import intersection_pkg::*;
#(
  parameter int STEP = STEP_DEF
) (
  input  logic [6:0] i_dur,
  input  logic [4:0] i_count,
  input  logic       i_rush,
  input  logic       i_sel_b,
  output logic [6:0] o_dur
);

  logic [7:0] w_adj;
  logic [6:0] w_lo;
  logic [6:0] w_hi;

  // 8-bit intermediate keeps dur+STEP and dur-STEP free of wrap before clamping
  always_comb begin
    w_adj = {1'b0, i_dur};
    if (i_count <= 5'd10)      w_adj = w_adj - 8'(STEP);
    else if (i_count >= 5'd20) w_adj = w_adj + 8'(STEP);
  end

  always_comb begin
    w_lo = i_rush ? A_MIN_RUSH : A_MIN_NORM;
    w_hi = i_rush ? A_MAX_RUSH : A_MAX_NORM;
    if (i_sel_b) begin
      w_lo = i_rush ? B_MIN_RUSH : B_MIN_NORM;
      w_hi = i_rush ? B_MAX_RUSH : B_MAX_NORM;
    end
  end

  assign o_dur = clamp_dur(w_adj, w_lo, w_hi);

endmodule

// File: rtl/intersection_phase_sequencer.sv
// Two-road phase sequencer: tick-paced green/yellow/all-red cycle with adaptive
// green durations and an operator-forced all-red HOLD via req/ack.
module intersection_phase_sequencer
  import intersection_pkg::*;
#(
  parameter int YELLOW_T = YELLOW_T_DEF,
  parameter int ALLRED_T = ALLRED_T_DEF,
  parameter int STEP     = STEP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [4:0] numOfCarsA,
  input  logic [4:0] numOfCarsB,
  input  logic       rushHour,
  input  logic       override_req,
  output logic       override_ack,
  output logic       greenForA,
  output logic       yellowForA,
  output logic       greenForB,
  output logic       yellowForB,
  output logic [2:0] phase,
  output logic [6:0] remainingTime,
  output logic [6:0] durA,
  output logic [6:0] durB
);

  localparam logic [6:0] YEL_LEN = 7'(YELLOW_T);
  localparam logic [6:0] AR_LEN  = 7'(ALLRED_T);

  phase_e     r_state, w_next_state;
  logic [6:0] r_rem, w_next_rem;
  logic [6:0] r_durA, r_durB, w_next_durA, w_next_durB;
  logic       r_hold_b, w_next_hold_b;
  logic       w_expire;
  logic       w_sel_b;
  logic [4:0] w_count;
  logic [6:0] w_cur_dur;
  logic [6:0] w_calc_dur;

  // Only one road adapts at a time: B leaving YELLOW_A, A leaving YELLOW_B
  assign w_sel_b   = (r_state == PH_YELLOW_A);
  assign w_count   = w_sel_b ? numOfCarsB : numOfCarsA;
  assign w_cur_dur = w_sel_b ? r_durB : r_durA;

  green_duration_calc #(.STEP(STEP)) u_calc (
    .i_dur   (w_cur_dur),
    .i_count (w_count),
    .i_rush  (rushHour),
    .i_sel_b (w_sel_b),
    .o_dur   (w_calc_dur)
  );

  assign w_expire = tick && (r_rem <= 7'd1);

  always_comb begin
    w_next_state  = r_state;
    w_next_rem    = r_rem;
    w_next_durA   = r_durA;
    w_next_durB   = r_durB;
    w_next_hold_b = r_hold_b;
    if (tick && !w_expire && (r_state != PH_HOLD)) w_next_rem = r_rem - 7'd1;
    case (r_state)
      PH_GREEN_A: if (override_req || w_expire) begin
        w_next_state = PH_YELLOW_A;
        w_next_rem   = YEL_LEN;
      end
      PH_YELLOW_A: if (w_expire) begin
        w_next_state = PH_ALLRED_AB;
        w_next_rem   = AR_LEN;
        w_next_durB  = w_calc_dur;
      end
      PH_ALLRED_AB: if (w_expire) begin
        if (override_req) begin
          w_next_state  = PH_HOLD;
          w_next_rem    = 7'd0;
          w_next_hold_b = 1'b1;
        end else begin
          w_next_state = PH_GREEN_B;
          w_next_rem   = r_durB;
        end
      end
      PH_GREEN_B: if (override_req || w_expire) begin
        w_next_state = PH_YELLOW_B;
        w_next_rem   = YEL_LEN;
      end
      PH_YELLOW_B: if (w_expire) begin
        w_next_state = PH_ALLRED_BA;
        w_next_rem   = AR_LEN;
        w_next_durA  = w_calc_dur;
      end
      PH_ALLRED_BA: if (w_expire) begin
        if (override_req) begin
          w_next_state  = PH_HOLD;
          w_next_rem    = 7'd0;
          w_next_hold_b = 1'b0;
        end else begin
          w_next_state = PH_GREEN_A;
          w_next_rem   = r_durA;
        end
      end
      PH_HOLD: if (!override_req) begin
        w_next_state = r_hold_b ? PH_GREEN_B : PH_GREEN_A;
        w_next_rem   = r_hold_b ? r_durB : r_durA;
      end
      default: begin
        w_next_state = PH_GREEN_A;
        w_next_rem   = r_durA;
      end
    endcase
  end

  // Lights and ack are registered from the next state so they switch with phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= PH_GREEN_A;
      r_rem        <= DUR_A_RST;
      r_durA       <= DUR_A_RST;
      r_durB       <= DUR_B_RST;
      r_hold_b     <= 1'b0;
      greenForA    <= 1'b1;
      yellowForA   <= 1'b0;
      greenForB    <= 1'b0;
      yellowForB   <= 1'b0;
      override_ack <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_rem        <= w_next_rem;
      r_durA       <= w_next_durA;
      r_durB       <= w_next_durB;
      r_hold_b     <= w_next_hold_b;
      greenForA    <= (w_next_state == PH_GREEN_A);
      yellowForA   <= (w_next_state == PH_YELLOW_A);
      greenForB    <= (w_next_state == PH_GREEN_B);
      yellowForB   <= (w_next_state == PH_YELLOW_B);
      override_ack <= (w_next_state == PH_HOLD);
    end
  end

  assign phase         = r_state;
  assign remainingTime = r_rem;
  assign durA          = r_durA;
  assign durB          = r_durB;

endmodule

// File: tb/tb_intersection_phase_sequencer.sv
// Directed bench for intersection_phase_sequencer: every phase change is
// checked against a queue of expected snapshots, plus spot checks in-phase.
module tb_intersection_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [4:0] numOfCarsA;
  logic [4:0] numOfCarsB;
  logic       rushHour;
  logic       override_req;
  logic       override_ack;
  logic       greenForA, yellowForA, greenForB, yellowForB;
  logic [2:0] phase;
  logic [6:0] remainingTime;
  logic [6:0] durA;
  logic [6:0] durB;

  intersection_phase_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick          (tick),
    .numOfCarsA    (numOfCarsA),
    .numOfCarsB    (numOfCarsB),
    .rushHour      (rushHour),
    .override_req  (override_req),
    .override_ack  (override_ack),
    .greenForA     (greenForA),
    .yellowForA    (yellowForA),
    .greenForB     (greenForB),
    .yellowForB    (yellowForB),
    .phase         (phase),
    .remainingTime (remainingTime),
    .durA          (durA),
    .durB          (durB)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ph;
    logic [6:0] rem;
    logic [6:0] da;
    logic [6:0] db;
    logic [3:0] lights;
    logic       ack;
  } obs_t;

  obs_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_trans = 0;

  function automatic obs_t mk(input int ph, input int rem, input int da, input int db);
    obs_t o;
    o.ph     = 3'(ph);
    o.rem    = 7'(rem);
    o.da     = 7'(da);
    o.db     = 7'(db);
    o.lights = {ph == 0, ph == 1, ph == 3, ph == 4};
    o.ack    = (ph == 6);
    return o;
  endfunction

  task automatic push(input int ph, input int rem, input int da, input int db);
    sb_q.push_back(mk(ph, rem, da, db));
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 tick = 1'b1;
      @(posedge clk); #1 tick = 1'b0;
    end
  endtask

  // One full cycle from the start of GREEN_A; nB/nA are the hand-computed adapted durations
  task automatic cycle_from_a(input int dA, input int dB, input int nB, input int nA);
    push(1, 3, dA, dB);
    push(2, 2, dA, nB);
    push(3, nB, dA, nB);
    push(4, 3, dA, nB);
    push(5, 2, nA, nB);
    push(0, nA, nA, nB);
    ticks(dA + 3 + 2 + nB + 3 + 2);
  endtask

  // Monitor: each phase change is the DUT "presenting" a new snapshot
  logic [2:0] prev_phase = 3'd0;
  always @(negedge clk) begin
    obs_t act, exp;
    if (phase != prev_phase) begin
      act = '{ph: phase, rem: remainingTime, da: durA, db: durB,
               lights: {greenForA, yellowForA, greenForB, yellowForB}, ack: override_ack};
      checks++;
      n_trans++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_transition #%0d phase %0d->%0d", n_trans, prev_phase, phase);
      end else begin
        exp = sb_q.pop_front();
        if (act != exp) begin
          errors++;
          $display("FAIL transition #%0d actual ph=%0d rem=%0d dA=%0d dB=%0d lt=%b ack=%b required ph=%0d rem=%0d dA=%0d dB=%0d lt=%b ack=%b",
                   n_trans, act.ph, act.rem, act.da, act.db, act.lights, act.ack,
                   exp.ph, exp.rem, exp.da, exp.db, exp.lights, exp.ack);
        end
      end
      prev_phase = phase;
    end
  end

  initial begin
    rst_n = 1'b1; tick = 1'b0; override_req = 1'b0; rushHour = 1'b0;
    numOfCarsA = 5'd15; numOfCarsB = 5'd15;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_phase", phase, 0);
    chk("rst_greenA", greenForA, 1);
    chk("rst_other_lights", {yellowForA, greenForB, yellowForB}, 0);
    chk("rst_rem", remainingTime, 40);
    chk("rst_durA", durA, 40);
    chk("rst_durB", durB, 50);
    chk("rst_ack", override_ack, 0);

    // Baseline cycle with mid-range queues: durations unchanged
    push(1, 3, 40, 50); push(2, 2, 40, 50); push(3, 50, 40, 50);
    ticks(39);
    chk("greenA_last_tick_rem", remainingTime, 1);
    chk("greenA_still", phase, 0);
    ticks(1);
    chk("yellowA_on", yellowForA, 1);
    chk("yellowA_rem", remainingTime, 3);
    ticks(5);
    chk("greenB_rem", remainingTime, 50);
    push(4, 3, 40, 50); push(5, 2, 40, 50); push(0, 40, 40, 50);
    ticks(55);

    // Normal mode: B grows by STEP each cycle up to its 80 ceiling, A pinned at 40 floor
    numOfCarsA = 5'd5; numOfCarsB = 5'd25;
    cycle_from_a(40, 50, 55, 40);
    chk("durB_55", durB, 55);
    cycle_from_a(40, 55, 60, 40);
    cycle_from_a(40, 60, 65, 40);
    cycle_from_a(40, 65, 70, 40);
    cycle_from_a(40, 70, 75, 40);
    cycle_from_a(40, 75, 80, 40);
    cycle_from_a(40, 80, 80, 40);
    chk("durB_ceiling_norm", durB, 80);

    // Rush hour windows
    rushHour = 1'b1;
    cycle_from_a(40, 80, 70, 35);
    chk("durA_rush_35", durA, 35);
    numOfCarsB = 5'd5;
    cycle_from_a(35, 70, 65, 30);
    cycle_from_a(30, 65, 60, 30);
    chk("durA_floor_rush", durA, 30);
    rushHour = 1'b0; numOfCarsA = 5'd25; numOfCarsB = 5'd15;
    cycle_from_a(30, 60, 60, 40);
    chk("durA_floor_norm_after_rush", durA, 40);

    // Override from GREEN_A into HOLD, then release to GREEN_B
    numOfCarsA = 5'd15;
    ticks(20);
    chk("greenA_rem20", remainingTime, 20);
    push(1, 3, 40, 60);
    @(posedge clk); #1 override_req = 1'b1;
    @(posedge clk); #1;
    chk("ovr_yellowA", yellowForA, 1);
    push(2, 2, 40, 60); push(6, 0, 40, 60);
    ticks(5);
    chk("hold_ack", override_ack, 1);
    ticks(3);
    chk("hold_phase_after_ticks", phase, 6);
    chk("hold_rem", remainingTime, 0);
    chk("hold_lights", {greenForA, yellowForA, greenForB, yellowForB}, 0);
    push(3, 60, 40, 60);
    @(posedge clk); #1 override_req = 1'b0;
    @(posedge clk); #1;
    chk("release_greenB", greenForB, 1);
    chk("release_ack", override_ack, 0);
    chk("release_rem", remainingTime, 60);

    // Override coinciding with tick in GREEN_B, then a 2-clk pulse in YELLOW_B
    push(4, 3, 40, 60);
    @(posedge clk); #1 tick = 1'b1; override_req = 1'b1;
    @(posedge clk); #1 tick = 1'b0; override_req = 1'b0;
    chk("ovr_tick_rem", remainingTime, 3);
    @(posedge clk); #1 override_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 override_req = 1'b0;
    push(5, 2, 40, 60); push(0, 40, 40, 60);
    ticks(5);
    chk("no_hold_greenA", phase, 0);
    chk("no_hold_ack", override_ack, 0);

    // Asynchronous reset mid GREEN_B with durB=65
    numOfCarsB = 5'd25;
    push(1, 3, 40, 60); push(2, 2, 40, 65); push(3, 65, 40, 65);
    ticks(45);
    ticks(10);
    chk("pre_reset_durB", durB, 65);
    push(0, 40, 40, 50);
    @(posedge clk); #1 rst_n = 1'b0;
    #2;
    chk("async_rst_phase", phase, 0);
    chk("async_rst_greenA", greenForA, 1);
    chk("async_rst_durB", durB, 50);
    chk("async_rst_rem", remainingTime, 40);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    @(negedge clk); #1;
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
